uart_pic_tx: RTL and testbench
==============================

// Module: uart_pic_tx
// PURPOSE
//  Frame-upload UART transmitter for the static-dehazing design: on a start pulse, reads PIC_BYTES
//  RGB332 pixels (default 16384) from the synchronous-read frame RAM and sends each as 8N1 on tx.
//  It is the PC-bound counterpart of the UART receiver that loads the picture. Used for
//  read-back/loopback of the stored or dehazed image.
// PARAMETERS
//  SYSTEM_CLOCK  50_000_000  board_clk frequency in Hz (benches override to 50000)
//  BAUD_RATE     9600        line rate in bit/s
//  PIC_BYTES     16384       bytes per frame (128x128 RGB332)
//  ADDR_W        14          RAM address width; must satisfy 2**ADDR_W >= PIC_BYTES
// PORTS
//  board_clk  in   1       sole clock, rising edge
//  sys_rst    in   1       reset: asynchronous, active-high
//  start      in   1       1-cycle pulse that begins a frame; honoured only when busy=0
//  rd_en      out  1       RAM read strobe, 1 cycle per byte
//  rd_addr    out  ADDR_W  RAM byte address, 0..PIC_BYTES-1
//  rd_data    in   8       RAM read data, valid exactly 1 cycle after rd_en
//  tx         out  1       serial line, idle/mark = 1, driven from a flop
//  busy       out  1       1 in every state except IDLE
//  done       out  1       1-cycle pulse after the last stop bit of a frame
// BEHAVIOUR
//  Reset values: tx=1, busy=0, done=0, rd_en=0, rd_addr=0. State=IDLE; all counters are 0.
//  BIT_CYCLES = SYSTEM_CLOCK/BAUD_RATE, truncated. It must be >=2; with the bench values it is 5.
//  FSM states and transitions:
//   - IDLE: a start pulse captures byte_idx=0 and moves to FETCH.
//   - FETCH: rd_en=1, rd_addr=byte_idx, for one cycle. Next state is LATCH.
//   - LATCH: shift register <= rd_data. Next state is SHIFT.
//   - SHIFT: 10 slots of BIT_CYCLES cycles each: start bit 0, then d0..d7 LSB first, then stop bit 1.
//     After the stop slot: if byte_idx==PIC_BYTES-1, go to DONE; otherwise byte_idx+1, go to FETCH.
//   - DONE: done=1 for one cycle, busy still 1. Next state is IDLE.
//  Timing and latency:
//   - start sampled at cycle k gives rd_en at k+1. tx falls at k+3.
//   - Byte period = 10*BIT_CYCLES+2 cycles. tx holds 1 through FETCH and LATCH, which extends the stop bit.
//   - Frame length = PIC_BYTES*(10*BIT_CYCLES+2)+1 cycles, measured from the first rd_en to done.
//  Boundary conditions:
//   - start while busy (including the DONE cycle) is ignored and has no side effects.
//   - A start in the cycle after done begins a new frame at address 0.
//   - byte_idx never passes PIC_BYTES-1 and never wraps. Each frame restarts at 0.
//   - Reset mid-frame: immediately forces tx=1 and the other outputs to reset values. The
//     truncated character is abandoned (the far end may log a framing error). There is no auto-resume.
//   - rd_data is sampled only in LATCH and ignored at all other times.
//  The bit counter is 0..BIT_CYCLES-1. The slot index is 0..9. No arithmetic is wider than ADDR_W or $clog2(BIT_CYCLES).
// STRUCTURE
//  Shared package pic_uart_pkg holds:
//   - the BIT_CYCLES derivation function
//   - the FSM state encodings (IDLE, FETCH, LATCH, SHIFT, DONE)
//   - the default frame constants (PIC_BYTES, ADDR_W). These are shared with the receiver side.
//  One sub-module, uart_tx_byte, is the byte serializer:
//   - inputs load and data[7:0]; outputs tx and byte_busy
//   - it owns the bit/slot counters
//  uart_pic_tx owns the FSM, byte_idx, the RAM interface, busy and done.
// TESTING
//  Bench values for all tests: SYSTEM_CLOCK=50000, BAUD_RATE=9600 (BIT_CYCLES=5), 10 ns clock.
//  1 Reset: hold sys_rst=1 -> tx=1, busy=0, done=0, rd_en=0, rd_addr=0. Toggling start has no effect.
//  2 PIC_BYTES=4, RAM={A5,3C,00,FF}, one start ->
//    - rd_addr sequence 0,1,2,3
//    - first character on tx is 0,1,0,1,0,0,1,0,1,1, each bit 5 cycles
//    - done pulses exactly once, 209 cycles after the first rd_en
//  3 Loopback: tx drives the existing UART receiver, full 16384-byte RGB332 frame -> every received
//    byte equals RAM[addr], no framing errors.
//  4 Pulse start during bit 3 of byte 1 -> ignored: address sequence and done count are unchanged.
//  5 Assert sys_rst during bit 4 of byte 2 -> tx=1 and busy=0 without waiting for a clock edge.
//    A following start resumes from rd_addr=0.
//  6 Start in the cycle after done -> second frame begins at rd_addr=0, with tx mark for >=2 cycles
//    between the frames. Start during the DONE cycle is ignored.

Source files
------------

// File: rtl/uart_pic_tx_pkg.sv
// Shared definitions for the picture UART pair: baud divisor, transmitter FSM encoding
// and the default frame geometry (128x128 RGB332).
package pic_uart_pkg;

  localparam int PIC_BYTES_DEF = 16384;
  localparam int ADDR_W_DEF    = 14;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } tx_state_e;

  // Clock cycles per UART bit, truncated; callers must keep the result >= 2.
  function automatic int bit_cycles(input int sys_clk, input int baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_pic_tx_if.sv
// Frame-RAM read port plus serial/status lines of the picture transmitter.
interface uart_pic_tx_if #(
  parameter int ADDR_W = pic_uart_pkg::ADDR_W_DEF
);
  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic              tx;
  logic              busy;
  logic              done;

  modport master (input start, rd_data, output rd_en, rd_addr, tx, busy, done);
  modport slave  (output start, rd_data, input rd_en, rd_addr, tx, busy, done);
endinterface

// File: rtl/uart_pic_tx_byte.sv
// 8N1 byte serializer: a load pulse captures a byte and plays start, d0..d7, stop,
// each held for BIT_CYCLES clocks. tx idles at mark.
module uart_tx_byte #(
  parameter int BIT_CYCLES = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       tx_o,
  output logic       byte_busy_o
);

  localparam int              BW        = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [BW-1:0]   BIT_LAST  = BW'(BIT_CYCLES - 1);
  localparam logic [3:0]      SLOT_LAST = 4'd9;

  logic [BW-1:0] bit_q;
  logic [3:0]    slot_q;
  logic          active_q;
  logic          tx_q;
  logic [8:0]    sh_q;
  logic          bit_end;

  assign bit_end = (bit_q == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q    <= '0;
      slot_q   <= '0;
      active_q <= 1'b0;
      tx_q     <= 1'b1;
    end else if (load_i) begin
      bit_q    <= '0;
      slot_q   <= '0;
      active_q <= 1'b1;
      tx_q     <= 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        bit_q <= '0;
        if (slot_q == SLOT_LAST) begin
          active_q <= 1'b0;
          slot_q   <= '0;
        end else begin
          slot_q <= slot_q + 4'd1;
          tx_q   <= sh_q[0];
        end
      end else begin
        bit_q <= bit_q + BW'(1);
      end
    end
  end

  // Data bits with the stop bit queued behind them; shifted once per slot boundary.
  always_ff @(posedge clk) begin
    if (load_i) begin
      sh_q <= {1'b1, data_i};
    end else if (active_q && bit_end && (slot_q != SLOT_LAST)) begin
      sh_q <= {1'b1, sh_q[8:1]};
    end
  end

  // Low in the final cycle of the stop slot so the caller can fetch with no gap.
  assign byte_busy_o = active_q && !((slot_q == SLOT_LAST) && bit_end);
  assign tx_o        = tx_q;

endmodule

// File: rtl/uart_pic_tx.sv
// Frame-upload transmitter: on start, reads PIC_BYTES bytes from a synchronous-read RAM
// and sends each as 8N1. FETCH/LATCH add two mark cycles after every stop bit.
module uart_pic_tx
  import pic_uart_pkg::*;
#(
  parameter int SYSTEM_CLOCK = 50_000_000,
  parameter int BAUD_RATE    = 9600,
  parameter int PIC_BYTES    = PIC_BYTES_DEF,
  parameter int ADDR_W       = ADDR_W_DEF
) (
  input  logic          board_clk,
  input  logic          sys_rst,
  uart_pic_tx_if.master bus
);

  localparam int                BIT_CYCLES = bit_cycles(SYSTEM_CLOCK, BAUD_RATE);
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(PIC_BYTES - 1);

  tx_state_e         state_q;
  logic [ADDR_W-1:0] byte_idx_q;
  logic              rd_en_q;
  logic              busy_q;
  logic              done_q;
  logic              byte_busy;
  logic              load;

  assign load = (state_q == ST_LATCH);

  uart_tx_byte #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_ser (
    .clk         (board_clk),
    .rst         (sys_rst),
    .load_i      (load),
    .data_i      (bus.rd_data),
    .tx_o        (bus.tx),
    .byte_busy_o (byte_busy)
  );

  always_ff @(posedge board_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      byte_idx_q <= '0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            byte_idx_q <= '0;
            rd_en_q    <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= ST_FETCH;
          end
        end
        ST_FETCH: state_q <= ST_LATCH;
        ST_LATCH: state_q <= ST_SHIFT;
        ST_SHIFT: begin
          if (!byte_busy) begin
            if (byte_idx_q == LAST_IDX) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              byte_idx_q <= byte_idx_q + ADDR_W'(1);
              rd_en_q    <= 1'b1;
              state_q    <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = byte_idx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_uart_pic_tx.sv
// Directed bench for uart_pic_tx with a 4-byte frame, 5 clocks per bit.
module tb_uart_pic_tx;

  localparam int SYS = 50000;
  localparam int BAUD = 9600;
  localparam int PB = 4;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_pic_tx_if #(.ADDR_W(AW)) bus ();

  uart_pic_tx #(
    .SYSTEM_CLOCK (SYS),
    .BAUD_RATE    (BAUD),
    .PIC_BYTES    (PB),
    .ADDR_W       (AW)
  ) dut (
    .board_clk (clk),
    .sys_rst   (rst),
    .bus       (bus)
  );

  logic [7:0] ram [PB] = '{8'hA5, 8'h3C, 8'h00, 8'hFF};

  int n_cmp = 0;
  int n_bad = 0;

  // Synchronous-read RAM; junk on the bus whenever no read was issued.
  always @(posedge clk) begin
    if (bus.rd_en === 1'b1) bus.rd_data <= ram[bus.rd_addr[1:0]];
    else                    bus.rd_data <= 8'h66;
  end

  int          cyc = 0;
  logic [AW-1:0] addr_log[$];
  int          first_rd = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  logic        busy_at_done = 1'b0;

  initial forever begin
    @(posedge clk);
    if (bus.rd_en === 1'b1) begin
      if (first_rd < 0) first_rd = cyc;
      addr_log.push_back(bus.rd_addr);
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      busy_at_done = bus.busy;
    end
    cyc++;
  end

  // Software 8N1 receiver sampling mid-bit.
  logic       rx_en = 1'b1;
  logic [7:0] rx_b;
  logic [7:0] rx_q[$];
  int         ferr = 0;

  initial forever begin
    @(negedge clk);
    if (rx_en && !rst && bus.tx === 1'b0) begin
      repeat (2) @(negedge clk);
      if (bus.tx !== 1'b0) ferr++;
      for (int i = 0; i < 8; i++) begin
        repeat (5) @(negedge clk);
        rx_b[i] = bus.tx;
      end
      repeat (5) @(negedge clk);
      if (bus.tx !== 1'b1) ferr++;
      rx_q.push_back(rx_b);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    addr_log.delete();
    rx_q.delete();
    first_rd = -1;
    done_cnt = 0;
    done_cyc = -1;
    ferr = 0;
  endtask

  // Returns at the negedge of the cycle after start was sampled (first rd_en cycle).
  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_addr(input int n, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (addr_log.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
    end
    @(negedge clk);
    n_cmp++; if (bus.tx !== 1'b1)     begin n_bad++; $display("FAIL reset_tx: got %b want 1", bus.tx); end
    n_cmp++; if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0)   begin n_bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_cmp++; if (bus.rd_en !== 1'b0)  begin n_bad++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
    n_cmp++; if (bus.rd_addr !== '0)  begin n_bad++; $display("FAIL reset_rd_addr: got %0d want 0", bus.rd_addr); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0)   begin n_bad++; $display("FAIL reset_no_start_busy: got %b want 0", bus.busy); end
    n_cmp++; if (addr_log.size() != 0) begin n_bad++; $display("FAIL reset_no_read: got %0d reads want 0", addr_log.size()); end
  endtask

  task automatic test_frame();
    bit ok;
    logic [9:0] exp_ch;
    exp_ch = {1'b1, 8'hA5, 1'b0};
    clear_logs();
    pulse_start();
    n_cmp++; if (bus.rd_en !== 1'b1)  begin n_bad++; $display("FAIL frame_first_rd_en: got %b want 1", bus.rd_en); end
    n_cmp++; if (bus.rd_addr !== '0)  begin n_bad++; $display("FAIL frame_first_addr: got %0d want 0", bus.rd_addr); end
    @(negedge clk);
    n_cmp++; if (bus.tx !== 1'b1)     begin n_bad++; $display("FAIL frame_latch_mark: got %b want 1", bus.tx); end
    for (int s = 0; s < 10; s++) begin
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        n_cmp++;
        if (bus.tx !== exp_ch[s]) begin
          n_bad++;
          $display("FAIL frame_char_bit slot %0d cyc %0d: got %b want %b", s, c, bus.tx, exp_ch[s]);
        end
      end
    end
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame_done_timeout: got no done want done"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
    // Inclusive span: first rd_en cycle through done cycle.
    n_cmp++; if (done_cyc - first_rd + 1 != 209) begin n_bad++; $display("FAIL frame_length: got %0d want 209", done_cyc - first_rd + 1); end
    n_cmp++; if (busy_at_done !== 1'b1) begin n_bad++; $display("FAIL frame_busy_in_done: got %b want 1", busy_at_done); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_after: got %b want 0", bus.busy); end
    n_cmp++; if (addr_log.size() != 4) begin n_bad++; $display("FAIL frame_addr_count: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      n_cmp++; if (addr_log[i] !== AW'(i)) begin n_bad++; $display("FAIL frame_addr[%0d]: got %0d want %0d", i, addr_log[i], i); end
    end
    n_cmp++; if (rx_q.size() != 4) begin n_bad++; $display("FAIL frame_rx_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      n_cmp++; if (rx_q[i] !== ram[i]) begin n_bad++; $display("FAIL frame_rx[%0d]: got %h want %h", i, rx_q[i], ram[i]); end
    end
    n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL frame_framing: got %0d errors want 0", ferr); end
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_logs();
    pulse_start();
    wait_addr(2, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_wait_byte1: got timeout want fetch"); end
    // Byte 1 start bit begins next cycle; 22 more negedges lands inside the d3 slot.
    repeat (22) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL busy_during_shift: got %b want 1", bus.busy); end
    bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL busy_done_timeout: got no done want done"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
    n_cmp++; if (addr_log.size() != 4) begin n_bad++; $display("FAIL busy_addr_count: got %0d want 4", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 4; i++) begin
      n_cmp++; if (addr_log[i] !== AW'(i)) begin n_bad++; $display("FAIL busy_addr[%0d]: got %0d want %0d", i, addr_log[i], i); end
    end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      n_cmp++; if (rx_q[i] !== ram[i]) begin n_bad++; $display("FAIL busy_rx[%0d]: got %h want %h", i, rx_q[i], ram[i]); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_logs();
    pulse_start();
    wait_addr(3, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_wait_byte2: got timeout want fetch"); end
    rx_en = 1'b0;
    repeat (27) @(negedge clk);
    n_cmp++; if (bus.tx !== 1'b0) begin n_bad++; $display("FAIL rmid_tx_before: got %b want 0", bus.tx); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.tx !== 1'b1)    begin n_bad++; $display("FAIL rmid_tx_async: got %b want 1", bus.tx); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL rmid_busy_async: got %b want 0", bus.busy); end
    n_cmp++; if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL rmid_rd_en_async: got %b want 0", bus.rd_en); end
    n_cmp++; if (bus.rd_addr !== '0) begin n_bad++; $display("FAIL rmid_addr_async: got %0d want 0", bus.rd_addr); end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resume: got %b want 0", bus.busy); end
    clear_logs();
    rx_en = 1'b1;
    pulse_start();
    n_cmp++; if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL rmid_restart_rd_en: got %b want 1", bus.rd_en); end
    n_cmp++; if (bus.rd_addr !== '0) begin n_bad++; $display("FAIL rmid_restart_addr: got %0d want 0", bus.rd_addr); end
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rmid_done_timeout: got no done want done"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (rx_q.size() != 4) begin n_bad++; $display("FAIL rmid_rx_count: got %0d want 4", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 4; i++) begin
      n_cmp++; if (rx_q[i] !== ram[i]) begin n_bad++; $display("FAIL rmid_rx[%0d]: got %h want %h", i, rx_q[i], ram[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_logs();
    pulse_start();
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done1_timeout: got no done want done"); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_busy_in_done: got %b want 1", bus.busy); end
    n_cmp++; if (bus.tx !== 1'b1)   begin n_bad++; $display("FAIL b2b_tx_done: got %b want 1", bus.tx); end
    bus.start = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.rd_en !== 1'b0) begin n_bad++; $display("FAIL b2b_start_in_done_ignored: got %b want 0", bus.rd_en); end
    n_cmp++; if (bus.busy !== 1'b0)  begin n_bad++; $display("FAIL b2b_idle_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.tx !== 1'b1)    begin n_bad++; $display("FAIL b2b_tx_idle: got %b want 1", bus.tx); end
    @(negedge clk) bus.start = 1'b0;
    n_cmp++; if (bus.rd_en !== 1'b1) begin n_bad++; $display("FAIL b2b_restart_rd_en: got %b want 1", bus.rd_en); end
    n_cmp++; if (bus.rd_addr !== '0) begin n_bad++; $display("FAIL b2b_restart_addr: got %0d want 0", bus.rd_addr); end
    n_cmp++; if (bus.tx !== 1'b1)    begin n_bad++; $display("FAIL b2b_tx_fetch: got %b want 1", bus.tx); end
    wait_done(400, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_done2_timeout: got no done want done"); end
    repeat (10) @(negedge clk);
    n_cmp++; if (done_cnt != 2) begin n_bad++; $display("FAIL b2b_done_count: got %0d want 2", done_cnt); end
    n_cmp++; if (addr_log.size() != 8) begin n_bad++; $display("FAIL b2b_addr_count: got %0d want 8", addr_log.size()); end
    for (int i = 0; i < addr_log.size() && i < 8; i++) begin
      n_cmp++; if (addr_log[i] !== AW'(i % 4)) begin n_bad++; $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, addr_log[i], i % 4); end
    end
    n_cmp++; if (rx_q.size() != 8) begin n_bad++; $display("FAIL b2b_rx_count: got %0d want 8", rx_q.size()); end
    for (int i = 0; i < rx_q.size() && i < 8; i++) begin
      n_cmp++; if (rx_q[i] !== ram[i % 4]) begin n_bad++; $display("FAIL b2b_rx[%0d]: got %h want %h", i, rx_q[i], ram[i % 4]); end
    end
    n_cmp++; if (ferr != 0) begin n_bad++; $display("FAIL b2b_framing: got %0d errors want 0", ferr); end
  endtask

  initial begin
    bus.start = 1'b0;
    test_reset();
    test_frame();
    test_busy_start();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
